id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly drives the ALU inputs BusA, BusB and ALUCtrl.
- Captures decoded operands and control from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Routes shift amount and immediates onto BusB.
- Handles stall and flush, and optionally detects load-use hazards.

---
 rtl/id_ex_operand_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and ALU operand selection.
// Optional load-use hazard detection is enabled by defining LOAD_USE_DETECT_EN.
module id_ex_operand_stage #(
  parameter int         DW       = 32,
  parameter int         RW       = 5,
  parameter logic [3:0] NOP_CTRL = 4'd8
) (
  input  logic          Clk,
  input  logic          Reset_L,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          IdValid,
  input  logic [DW-1:0] IdRsData,
  input  logic [DW-1:0] IdRtData,
  input  logic [DW-1:0] IdImm,
  input  logic [4:0]    IdShamt,
  input  logic [RW-1:0] IdRs,
  input  logic [RW-1:0] IdRt,
  input  logic [RW-1:0] IdRw,
  input  logic [3:0]    IdALUCtrl,
  input  logic          IdALUSrc,
  input  logic          IdShiftSel,
  input  logic          IdRegWrite,
  input  logic          IdMemRead,
  input  logic          IdMemWrite,
  input  logic          ExMemRegWrite,
  input  logic [RW-1:0] ExMemRw,
  input  logic [DW-1:0] ExMemResult,
  input  logic          MemWbRegWrite,
  input  logic [RW-1:0] MemWbRw,
  input  logic [DW-1:0] MemWbData,
  output logic [DW-1:0] BusA,
  output logic [DW-1:0] BusB,
  output logic [3:0]    ALUCtrl,
  output logic [DW-1:0] ExStoreData,
  output logic [RW-1:0] ExRw,
  output logic          ExRegWrite,
  output logic          ExMemRead,
  output logic          ExMemWrite,
  output logic          ExValid,
  output logic          HazardStall
);

  // Flow control: the stage has no valid/ready pair. Flush beats Stall beats
  // load; a stalled stage keeps its instruction, and an invalid or
  // hazard-blocked ID slot becomes a bubble whose write enables are all 0.

  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          alu_src_q, alu_src_d;
  logic          shift_sel_q, shift_sel_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rw_q, rw_d;
  logic [DW-1:0] fwd_rs, fwd_rt;
  logic          load_use;

`ifdef LOAD_USE_DETECT_EN
  assign load_use = valid_q & mem_read_q & (rw_q != '0) & IdValid &
                    ((rw_q == IdRs) | (rw_q == IdRt));
`else
  assign load_use = 1'b0;
`endif

  function automatic logic [DW-1:0] forward(
    input logic [RW-1:0] src,
    input logic [DW-1:0] held,
    input logic          em_we,
    input logic [RW-1:0] em_rw,
    input logic [DW-1:0] em_data,
    input logic          mw_we,
    input logic [RW-1:0] mw_rw,
    input logic [DW-1:0] mw_data
  );
    if (src == '0)                        return '0;
    else if (em_we && (em_rw == src))     return em_data;
    else if (mw_we && (mw_rw == src))     return mw_data;
    else                                  return held;
  endfunction

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_src_d   = alu_src_q;
    shift_sel_d = shift_sel_q;
    alu_ctrl_d  = alu_ctrl_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rw_d        = rw_q;
    if (Flush || (!Stall && (!IdValid || load_use))) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      alu_src_d   = 1'b0;
      shift_sel_d = 1'b0;
      alu_ctrl_d  = NOP_CTRL;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      shamt_d     = '0;
      rs_d        = '0;
      rt_d        = '0;
      rw_d        = '0;
    end else if (Stall) begin
      // A write-back retiring while we wait would otherwise be lost.
      if (MemWbRegWrite && (MemWbRw != '0) && (MemWbRw == rs_q)) rs_data_d = MemWbData;
      if (MemWbRegWrite && (MemWbRw != '0) && (MemWbRw == rt_q)) rt_data_d = MemWbData;
    end else begin
      valid_d     = 1'b1;
      reg_write_d = IdRegWrite;
      mem_read_d  = IdMemRead;
      mem_write_d = IdMemWrite;
      alu_src_d   = IdALUSrc;
      shift_sel_d = IdShiftSel;
      alu_ctrl_d  = IdALUCtrl;
      rs_data_d   = IdRsData;
      rt_data_d   = IdRtData;
      imm_d       = IdImm;
      shamt_d     = IdShamt;
      rs_d        = IdRs;
      rt_d        = IdRt;
      rw_d        = IdRw;
    end
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      shift_sel_q <= 1'b0;
      alu_ctrl_q  <= NOP_CTRL;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rw_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_src_q   <= alu_src_d;
      shift_sel_q <= shift_sel_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rw_q        <= rw_d;
    end
  end

  always_comb begin
    fwd_rs = forward(rs_q, rs_data_q, ExMemRegWrite, ExMemRw, ExMemResult,
                     MemWbRegWrite, MemWbRw, MemWbData);
    fwd_rt = forward(rt_q, rt_data_q, ExMemRegWrite, ExMemRw, ExMemResult,
                     MemWbRegWrite, MemWbRw, MemWbData);
  end

  // Constant shifts take the value from rt and the amount from shamt.
  assign BusA        = shift_sel_q ? fwd_rt : fwd_rs;
  assign BusB        = shift_sel_q ? {{(DW-5){1'b0}}, shamt_q} : (alu_src_q ? imm_q : fwd_rt);
  assign ALUCtrl     = alu_ctrl_q;
  assign ExStoreData = fwd_rt;
  assign ExRw        = rw_q;
  assign ExRegWrite  = reg_write_q;
  assign ExMemRead   = mem_read_q;
  assign ExMemWrite  = mem_write_q;
  assign ExValid     = valid_q;
  assign HazardStall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: table vectors, random vectors
// through a scoreboard queue, and hand-written forwarding/stall/hazard/reset sequences.
module tb_id_ex_operand_stage;

  logic        clk, rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rw;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_shift_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        em_we, mw_we;
  logic [4:0]  em_rw, mw_rw;
  logic [31:0] em_result, mw_data;
  logic [31:0] bus_a, bus_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rw;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, hazard_stall;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage dut (
    .Clk(clk), .Reset_L(rst_n), .Stall(stall), .Flush(flush), .IdValid(id_valid),
    .IdRsData(id_rs_data), .IdRtData(id_rt_data), .IdImm(id_imm), .IdShamt(id_shamt),
    .IdRs(id_rs), .IdRt(id_rt), .IdRw(id_rw), .IdALUCtrl(id_alu_ctrl),
    .IdALUSrc(id_alu_src), .IdShiftSel(id_shift_sel), .IdRegWrite(id_reg_write),
    .IdMemRead(id_mem_read), .IdMemWrite(id_mem_write),
    .ExMemRegWrite(em_we), .ExMemRw(em_rw), .ExMemResult(em_result),
    .MemWbRegWrite(mw_we), .MemWbRw(mw_rw), .MemWbData(mw_data),
    .BusA(bus_a), .BusB(bus_b), .ALUCtrl(alu_ctrl), .ExStoreData(ex_store_data),
    .ExRw(ex_rw), .ExRegWrite(ex_reg_write), .ExMemRead(ex_mem_read),
    .ExMemWrite(ex_mem_write), .ExValid(ex_valid), .HazardStall(hazard_stall)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  rs, rt, rw;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic [3:0]  ctrl;
    logic        alu_src, shift_sel, rwe, mrd, mwr;
    logic [31:0] e_a, e_b, e_st;
    logic [3:0]  e_ctrl;
  } vec_t;

  typedef struct packed {
    logic [31:0] a, b, st;
    logic [3:0]  ctrl;
    logic [4:0]  rw;
    logic        rwe, mrd, mwr, vld, chk_bus;
  } out_t;

  localparam int EW = $bits(out_t);
  logic [EW-1:0] exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld;    id_rs = v.rs;           id_rt = v.rt;         id_rw = v.rw;
    id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;    id_shamt = v.shamt;
    id_alu_ctrl = v.ctrl; id_alu_src = v.alu_src; id_shift_sel = v.shift_sel;
    id_reg_write = v.rwe; id_mem_read = v.mrd;    id_mem_write = v.mwr;
  endtask

  task automatic push_exp(input vec_t v);
    out_t o;
    o.a = v.e_a; o.b = v.e_b; o.st = v.e_st;
    o.ctrl = v.vld ? v.e_ctrl : 4'd8;
    o.rw = v.rw; o.rwe = v.vld & v.rwe; o.mrd = v.vld & v.mrd; o.mwr = v.vld & v.mwr;
    o.vld = v.vld; o.chk_bus = v.vld;
    exp_q.push_back(o);
  endtask

  task automatic sb_check();
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_valid", {31'b0, ex_valid}, {31'b0, e.vld});
      check("sb_ctrl", {28'b0, alu_ctrl}, {28'b0, e.ctrl});
      check("sb_regwrite", {31'b0, ex_reg_write}, {31'b0, e.rwe});
      check("sb_memread", {31'b0, ex_mem_read}, {31'b0, e.mrd});
      check("sb_memwrite", {31'b0, ex_mem_write}, {31'b0, e.mwr});
      if (e.chk_bus) begin
        check("sb_bus_a", bus_a, e.a);
        check("sb_bus_b", bus_b, e.b);
        check("sb_store", ex_store_data, e.st);
        check("sb_rw", {27'b0, ex_rw}, {27'b0, e.rw});
      end
    end
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rw = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alu_ctrl = 0; id_alu_src = 0; id_shift_sel = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  initial begin
    vec_t r;
    logic [31:0] rsv, rtv;
    // vld rs rt rw rs_data rt_data imm shamt ctrl src shf rwe mrd mwr | e_a e_b e_st e_ctrl
    vecs[0] = '{1, 5'd1, 5'd2, 5'd3, 32'h00000001, 32'hFFFFFFFF, 32'h0, 5'd0, 4'd9, 0, 0, 1, 0, 0,
                32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9};
    vecs[1] = '{1, 5'd4, 5'd2, 5'd3, 32'h00000055, 32'hFFFF1234, 32'h0, 5'd6, 4'd13, 0, 1, 1, 0, 0,
                32'hFFFF1234, 32'h00000006, 32'hFFFF1234, 4'd13};
    vecs[2] = '{1, 5'd6, 5'd7, 5'd0, 32'h00000100, 32'h00000077, 32'h0000ABCD, 5'd0, 4'd8, 1, 0, 0, 0, 1,
                32'h00000100, 32'h0000ABCD, 32'h00000077, 4'd8};
    vecs[3] = '{1, 5'd2, 5'd8, 5'd9, 32'h00000002, 32'hDEAD0000, 32'h00000123, 5'd31, 4'd12, 1, 1, 1, 0, 0,
                32'hDEAD0000, 32'h0000001F, 32'hDEAD0000, 4'd12};
    vecs[4] = '{1, 5'd0, 5'd0, 5'd4, 32'hFFFFFFFF, 32'h12345678, 32'h0, 5'd0, 4'd1, 0, 0, 1, 0, 0,
                32'h0, 32'h0, 32'h0, 4'd1};
    vecs[5] = '{0, 5'd3, 5'd4, 5'd5, 32'h11111111, 32'h22222222, 32'h0, 5'd3, 4'd2, 0, 0, 1, 1, 1,
                32'h0, 32'h0, 32'h0, 4'd8};
    vecs[6] = '{1, 5'd9, 5'd11, 5'd10, 32'h00001000, 32'h0, 32'hFFFFFFFC, 5'd0, 4'd8, 1, 0, 1, 1, 0,
                32'h00001000, 32'hFFFFFFFC, 32'h0, 4'd8};

    // Reset block
    rst_n = 0; stall = 0; flush = 0;
    em_we = 0; em_rw = 0; em_result = 0; mw_we = 0; mw_rw = 0; mw_data = 0;
    idle_id();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("rst_bus_a", bus_a, 32'h0);
    check("rst_bus_b", bus_b, 32'h0);
    check("rst_ctrl", {28'b0, alu_ctrl}, 32'd8);
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_store", ex_store_data, 32'h0);
    check("rst_hazard", {31'b0, hazard_stall}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sb_check();
      drive(vecs[i]);
      push_exp(vecs[i]);
    end
    @(negedge clk);
    sb_check();
    idle_id();

    // Random vectors with forward sources idle; no loads so no hazard bubbles.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sb_check();
      r.vld = ($urandom_range(0, 3) != 0);
      r.rs = 5'($urandom_range(0, 31)); r.rt = 5'($urandom_range(0, 31));
      r.rw = 5'($urandom_range(0, 31));
      r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
      r.shamt = 5'($urandom_range(0, 31)); r.ctrl = 4'($urandom_range(0, 15));
      r.alu_src = 1'($urandom_range(0, 1)); r.shift_sel = 1'($urandom_range(0, 1));
      r.rwe = 1'($urandom_range(0, 1)); r.mrd = 0; r.mwr = 1'($urandom_range(0, 1));
      rsv = (r.rs == 0) ? 32'h0 : r.rs_data;
      rtv = (r.rt == 0) ? 32'h0 : r.rt_data;
      r.e_a = r.shift_sel ? rtv : rsv;
      r.e_b = r.shift_sel ? {27'b0, r.shamt} : (r.alu_src ? r.imm : rtv);
      r.e_st = rtv; r.e_ctrl = r.ctrl;
      drive(r);
      push_exp(r);
    end
    @(negedge clk);
    sb_check();
    idle_id();
    check("sb_drained", exp_q.size(), 32'd0);

    // Forwarding priority on rs/rt.
    id_valid = 1; id_rs = 5; id_rs_data = 32'h11111111; id_rt = 5; id_rt_data = 32'h22222222;
    @(negedge clk);
    idle_id();
    em_we = 1; em_rw = 5; em_result = 32'hAAAA0000;
    mw_we = 1; mw_rw = 5; mw_data = 32'h12345678;
    #1 check("fwd_exmem_a", bus_a, 32'hAAAA0000);
    check("fwd_exmem_st", ex_store_data, 32'hAAAA0000);
    em_we = 0;
    #1 check("fwd_memwb_a", bus_a, 32'h12345678);
    check("fwd_memwb_b", bus_b, 32'h12345678);
    mw_we = 0;
    #1 check("fwd_none_a", bus_a, 32'h11111111);
    id_valid = 1; id_rs = 0; id_rs_data = 32'hDEADBEEF; id_rt = 0; id_rt_data = 32'hCAFEF00D;
    @(negedge clk);
    em_we = 1; em_rw = 0; em_result = 32'hAAAA0000;
    mw_we = 1; mw_rw = 0; mw_data = 32'h12345678;
    #1 check("fwd_r0_a", bus_a, 32'h0);
    check("fwd_r0_b", bus_b, 32'h0);
    em_we = 0; mw_we = 0;

    // Stall with a write-back retiring into the held rt, then flush+stall.
    id_valid = 1; id_rs = 3; id_rs_data = 32'h3; id_rt = 7; id_rt_data = 32'h11112222;
    id_alu_ctrl = 6; id_reg_write = 1;
    @(negedge clk);
    stall = 1; mw_we = 1; mw_rw = 7; mw_data = 32'h0000BEEF;
    id_rt_data = 32'h99; id_alu_ctrl = 2;
    repeat (2) @(negedge clk);
    mw_we = 0;
    #1 check("stall_refresh_b", bus_b, 32'h0000BEEF);
    check("stall_hold_a", bus_a, 32'h3);
    check("stall_hold_ctrl", {28'b0, alu_ctrl}, 32'd6);
    check("stall_hold_valid", {31'b0, ex_valid}, 32'd1);
    flush = 1;
    @(posedge clk);
    #1 check("flush_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_ctrl", {28'b0, alu_ctrl}, 32'd8);
    check("flush_regwrite", {31'b0, ex_reg_write}, 32'd0);
    @(negedge clk);
    flush = 0; stall = 0;

    // Load followed by a dependent instruction.
    idle_id();
    id_valid = 1; id_rs = 1; id_rt = 2; id_rw = 3; id_mem_read = 1; id_reg_write = 1; id_alu_src = 1;
    @(negedge clk);
    idle_id();
    id_valid = 1; id_rs = 3; id_rt = 4; id_rw = 5;
    #1;
`ifdef LOAD_USE_DETECT_EN
    check("lu_hazard", {31'b0, hazard_stall}, 32'd1);
    @(negedge clk);
    check("lu_bubble", {31'b0, ex_valid}, 32'd0);
`else
    check("lu_hazard_off", {31'b0, hazard_stall}, 32'd0);
    @(negedge clk);
    check("lu_no_bubble", {31'b0, ex_valid}, 32'd1);
`endif
    idle_id();
    id_valid = 1; id_rs = 0; id_rt = 2; id_rw = 0; id_mem_read = 1; id_reg_write = 1;
    @(negedge clk);
    idle_id();
    id_valid = 1; id_rs = 0; id_rt = 0; id_rw = 6;
    #1 check("lu_r0_hazard", {31'b0, hazard_stall}, 32'd0);
    @(negedge clk);
    check("lu_r0_valid", {31'b0, ex_valid}, 32'd1);

    // Asynchronous reset mid-cycle with a valid instruction held.
    idle_id();
    id_valid = 1; id_rs = 1; id_rs_data = 32'h5; id_rt = 2; id_rt_data = 32'h7;
    id_alu_ctrl = 3; id_reg_write = 1; id_mem_write = 1;
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("arst_valid", {31'b0, ex_valid}, 32'd0);
    check("arst_ctrl", {28'b0, alu_ctrl}, 32'd8);
    check("arst_bus_a", bus_a, 32'h0);
    check("arst_bus_b", bus_b, 32'h0);
    check("arst_wen", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle_id();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
